tim_apb_master: RTL and testbench

APB4 initiator that drives the timer's APB slave port (tim_psel/tim_penable/tim_paddr/tim_pwdata/tim_pstrb/tim_pwrite; samples tim_prdata/tim_pready/tim_pslverr). It converts a simple valid/ready command interface into one APB transfer at a time and returns read data and error status on a response handshake. A programmable wait-state timeout aborts transfers whose slave never asserts tim_pready. It sits between a bus bridge or test sequencer and the timer top.

---
 rtl/tim_apb_master_if.sv | 46 ++++
 rtl/tim_apb_master.sv | 172 +++++++++++++++++
 tb/tb_tim_apb_master.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tim_apb_master_if.sv
// Command, response and APB signal bundle for the timer APB initiator.
// The master modport is the initiator's view; the slave modport is the
// view of everything around it (command source, response sink, APB target).
interface tim_apb_master_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  // APB4 towards the timer
  logic        tim_psel;
  logic        tim_penable;
  logic        tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata;
  logic        tim_pready;
  logic        tim_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_prdata, tim_pready, tim_pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_prdata, tim_pready, tim_pslverr
  );
endinterface

// File: rtl/tim_apb_master.sv
// APB4 initiator for the timer block. Accepts one command at a time on a
// valid/ready channel, runs a single SETUP/ACCESS transfer and presents the
// result on a response channel that is held until accepted. Slaves that
// never assert pready are aborted after TIMEOUT_CYC ACCESS cycles (0 = never).
module tim_apb_master #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  tim_apb_master_if.master     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_t;

  // Timeout compare value: the ACCESS cycle index on which the abort fires.
  localparam bit          TIMEOUT_EN_C   = (TIMEOUT_CYC != 32'd0);
  localparam logic [15:0] TIMEOUT_LAST_C = (TIMEOUT_CYC == 32'd0) ? 16'd0
                                           : 16'(TIMEOUT_CYC - 32'd1);

  state_t      state_r, state_nxt_s;

  logic        psel_r,        psel_nxt_s;
  logic        penable_r,     penable_nxt_s;
  logic        pwrite_r,      pwrite_nxt_s;
  logic [11:0] paddr_r,       paddr_nxt_s;
  logic [31:0] pwdata_r,      pwdata_nxt_s;
  logic [3:0]  pstrb_r,       pstrb_nxt_s;
  logic        rsp_valid_r,   rsp_valid_nxt_s;
  logic [31:0] rsp_rdata_r,   rsp_rdata_nxt_s;
  logic        rsp_err_r,     rsp_err_nxt_s;
  logic        rsp_timeout_r, rsp_timeout_nxt_s;
  logic [15:0] wait_cnt_r,    wait_cnt_nxt_s;

  // State register; reset drops any in-flight transfer back to IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_nxt_s       = state_r;
    psel_nxt_s        = psel_r;
    penable_nxt_s     = penable_r;
    pwrite_nxt_s      = pwrite_r;
    paddr_nxt_s       = paddr_r;
    pwdata_nxt_s      = pwdata_r;
    pstrb_nxt_s       = pstrb_r;
    rsp_valid_nxt_s   = rsp_valid_r;
    rsp_rdata_nxt_s   = rsp_rdata_r;
    rsp_err_nxt_s     = rsp_err_r;
    rsp_timeout_nxt_s = rsp_timeout_r;
    wait_cnt_nxt_s    = wait_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          // Reads carry no write data or strobes on APB4.
          state_nxt_s   = ST_SETUP;
          psel_nxt_s    = 1'b1;
          penable_nxt_s = 1'b0;
          pwrite_nxt_s  = bus.cmd_write;
          paddr_nxt_s   = bus.cmd_addr;
          pwdata_nxt_s  = bus.cmd_write ? bus.cmd_wdata : 32'd0;
          pstrb_nxt_s   = bus.cmd_write ? bus.cmd_strb  : 4'b0000;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end

      ST_SETUP: begin
        state_nxt_s    = ST_ACCESS;
        psel_nxt_s     = 1'b1;
        penable_nxt_s  = 1'b1;
        wait_cnt_nxt_s = 16'd0;
      end

      ST_ACCESS: begin
        if (bus.tim_pready) begin
          // Completion takes priority over a timeout in the same cycle.
          state_nxt_s       = ST_RESP;
          psel_nxt_s        = 1'b0;
          penable_nxt_s     = 1'b0;
          rsp_valid_nxt_s   = 1'b1;
          rsp_rdata_nxt_s   = pwrite_r ? 32'd0 : bus.tim_prdata;
          rsp_err_nxt_s     = bus.tim_pslverr;
          rsp_timeout_nxt_s = 1'b0;
        end else if (TIMEOUT_EN_C && (wait_cnt_r == TIMEOUT_LAST_C)) begin
          state_nxt_s       = ST_RESP;
          psel_nxt_s        = 1'b0;
          penable_nxt_s     = 1'b0;
          rsp_valid_nxt_s   = 1'b1;
          rsp_rdata_nxt_s   = 32'd0;
          rsp_err_nxt_s     = 1'b1;
          rsp_timeout_nxt_s = 1'b1;
          wait_cnt_nxt_s    = wait_cnt_r + 16'd1;
        end else begin
          wait_cnt_nxt_s    = wait_cnt_r + 16'd1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s     = ST_IDLE;
          rsp_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s     = ST_RESP;
          rsp_valid_nxt_s = 1'b1;
        end
      end

      default: begin
        state_nxt_s     = ST_IDLE;
        psel_nxt_s      = 1'b0;
        penable_nxt_s   = 1'b0;
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; all clear on reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= 12'd0;
      pwdata_r      <= 32'd0;
      pstrb_r       <= 4'b0000;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 32'd0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      wait_cnt_r    <= 16'd0;
    end else begin
      psel_r        <= psel_nxt_s;
      penable_r     <= penable_nxt_s;
      pwrite_r      <= pwrite_nxt_s;
      paddr_r       <= paddr_nxt_s;
      pwdata_r      <= pwdata_nxt_s;
      pstrb_r       <= pstrb_nxt_s;
      rsp_valid_r   <= rsp_valid_nxt_s;
      rsp_rdata_r   <= rsp_rdata_nxt_s;
      rsp_err_r     <= rsp_err_nxt_s;
      rsp_timeout_r <= rsp_timeout_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
    end
  end

  // cmd_ready follows the state directly so it is high throughout reset.
  assign bus.cmd_ready   = (state_r == ST_IDLE);

  assign bus.tim_psel    = psel_r;
  assign bus.tim_penable = penable_r;
  assign bus.tim_pwrite  = pwrite_r;
  assign bus.tim_paddr   = paddr_r;
  assign bus.tim_pwdata  = pwdata_r;
  assign bus.tim_pstrb   = pstrb_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_tim_apb_master.sv
// Bench for tim_apb_master: directed scenarios followed by random
// transactions, each checked against a transaction-level reference model.
module tb_tim_apb_master;

  localparam int TO = 4;

  logic sys_clk;
  logic sys_rst_n;
  int   checks;
  int   errors;

  tim_apb_master_if bus ();

  tim_apb_master #(.TIMEOUT_CYC(TO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_psel"},    32'(bus.tim_psel),    32'd0);
    chk({tag, "_penable"}, 32'(bus.tim_penable), 32'd0);
    chk({tag, "_pwrite"},  32'(bus.tim_pwrite),  32'd0);
    chk({tag, "_paddr"},   32'(bus.tim_paddr),   32'd0);
    chk({tag, "_pwdata"},  bus.tim_pwdata,       32'd0);
    chk({tag, "_pstrb"},   32'(bus.tim_pstrb),   32'd0);
    chk({tag, "_rvalid"},  32'(bus.rsp_valid),   32'd0);
    chk({tag, "_rdata"},   bus.rsp_rdata,        32'd0);
    chk({tag, "_rerr"},    32'(bus.rsp_err),     32'd0);
    chk({tag, "_rto"},     32'(bus.rsp_timeout), 32'd0);
    chk({tag, "_cready"},  32'(bus.cmd_ready),   32'd1);
  endtask

  task automatic scramble_cmd();
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 12'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = 4'($urandom);
  endtask

  // One complete transaction. Called at a negedge with the DUT idle.
  // waits = slave wait states before pready; hold = cycles rsp_ready stays low.
  task automatic do_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int waits, input logic [31:0] rd,
                        input logic se, input int hold);
    logic        exp_to;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    int          acc_len;
    int          k;
    int          lat;
    bit          done;

    // Reference model of the transfer outcome.
    exp_to  = (TO != 0) && (waits >= TO);
    acc_len = exp_to ? TO : waits + 1;
    exp_err = exp_to ? 1'b1 : se;
    exp_rd  = (exp_to || wr) ? 32'd0 : rd;
    exp_wd  = wr ? wd : 32'd0;
    exp_st  = wr ? st : 4'b0000;

    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_strb  = st;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.cmd_valid = 1'b0;
    scramble_cmd();

    chk("setup_psel",    32'(bus.tim_psel),    32'd1);
    chk("setup_penable", 32'(bus.tim_penable), 32'd0);
    chk("setup_paddr",   32'(bus.tim_paddr),   32'(addr));
    chk("setup_pwrite",  32'(bus.tim_pwrite),  32'(wr));
    chk("setup_pwdata",  bus.tim_pwdata,       exp_wd);
    chk("setup_pstrb",   32'(bus.tim_pstrb),   32'(exp_st));
    chk("setup_cready",  32'(bus.cmd_ready),   32'd0);
    bus.tim_pready  = 1'($urandom);
    bus.tim_prdata  = $urandom;
    bus.tim_pslverr = 1'($urandom);

    k    = 0;
    lat  = 1;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      lat++;
      bus.cmd_valid = 1'($urandom);
      scramble_cmd();
      if (bus.rsp_valid) begin
        done = 1'b1;
      end else if (bus.tim_psel && bus.tim_penable) begin
        chk("access_paddr",  32'(bus.tim_paddr), 32'(addr));
        chk("access_pwdata", bus.tim_pwdata,     exp_wd);
        bus.tim_pready  = (k == waits);
        bus.tim_prdata  = (k == waits) ? rd : $urandom;
        bus.tim_pslverr = (k == waits) ? se : 1'($urandom);
        k++;
      end else begin
        bus.tim_pready = 1'b0;
      end
    end
    bus.cmd_valid  = 1'b0;
    bus.tim_pready = 1'b0;

    chk("rsp_seen",      32'(done),              32'd1);
    chk("rsp_latency",   32'(lat),               32'(acc_len + 2));
    chk("access_cycles", 32'(k),                 32'(acc_len));
    chk("rsp_rdata",     bus.rsp_rdata,          exp_rd);
    chk("rsp_err",       32'(bus.rsp_err),       32'(exp_err));
    chk("rsp_timeout",   32'(bus.rsp_timeout),   32'(exp_to));
    chk("rsp_psel",      32'(bus.tim_psel),      32'd0);
    chk("rsp_penable",   32'(bus.tim_penable),   32'd0);
    chk("rsp_cready",    32'(bus.cmd_ready),     32'd0);
    chk("rsp_pstrb",     32'(bus.tim_pstrb),     32'(exp_st));

    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      scramble_cmd();
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("hold_rvalid",  32'(bus.rsp_valid),   32'd1);
      chk("hold_rdata",   bus.rsp_rdata,        exp_rd);
      chk("hold_rerr",    32'(bus.rsp_err),     32'(exp_err));
      chk("hold_rto",     32'(bus.rsp_timeout), 32'(exp_to));
      chk("hold_cready",  32'(bus.cmd_ready),   32'd0);
      chk("hold_psel",    32'(bus.tim_psel),    32'd0);
      chk("hold_paddr",   32'(bus.tim_paddr),   32'(addr));
    end

    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.rsp_ready = 1'b0;
    chk("done_rvalid", 32'(bus.rsp_valid), 32'd0);
    chk("done_cready", 32'(bus.cmd_ready), 32'd1);
    chk("done_paddr",  32'(bus.tim_paddr), 32'(addr));
    chk("done_psel",   32'(bus.tim_psel),  32'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    sys_rst_n       = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = 12'd0;
    bus.cmd_wdata   = 32'd0;
    bus.cmd_strb    = 4'd0;
    bus.rsp_ready   = 1'b0;
    bus.tim_prdata  = 32'd0;
    bus.tim_pready  = 1'b0;
    bus.tim_pslverr = 1'b0;

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge sys_clk);
    chk_reset_vals("rst");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Zero-wait write.
    do_txn(1'b1, 12'h004, 32'hDEAD_BEEF, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, 0);
    // Read with three wait states.
    do_txn(1'b0, 12'h010, 32'hAAAA_5555, 4'hF, 3, 32'h1234_5678, 1'b0, 0);
    // Slave errors on a write and on a read.
    do_txn(1'b1, 12'h020, 32'h0BAD_F00D, 4'h3, 1, 32'h0, 1'b1, 0);
    do_txn(1'b0, 12'h024, 32'h0, 4'hF, 2, 32'hCAFE_0001, 1'b1, 0);
    // Timeout with pready held low, then pready on the last allowed cycle.
    do_txn(1'b0, 12'h030, 32'h0, 4'h0, 100, 32'h5A5A_5A5A, 1'b0, 0);
    do_txn(1'b0, 12'h034, 32'h0, 4'h0, TO - 1, 32'h0F0F_0F0F, 1'b0, 0);
    // Response back-pressure for five cycles, then a normal command.
    do_txn(1'b1, 12'h040, 32'h1111_2222, 4'hC, 0, 32'h0, 1'b0, 5);
    do_txn(1'b0, 12'h044, 32'h0, 4'hF, 0, 32'h3333_4444, 1'b0, 0);

    // Reset asserted mid-ACCESS.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h050;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.cmd_valid  = 1'b0;
    bus.tim_pready = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("pre_rst_access", 32'(bus.tim_psel && bus.tim_penable), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_psel",    32'(bus.tim_psel),    32'd0);
    chk("async_penable", 32'(bus.tim_penable), 32'd0);
    chk("async_cready",  32'(bus.cmd_ready),   32'd1);
    chk("async_rvalid",  32'(bus.rsp_valid),   32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk_reset_vals("post_rst");
    do_txn(1'b0, 12'h054, 32'h0, 4'hF, 1, 32'h8765_4321, 1'b0, 0);

    // Random transactions.
    for (int n = 0; n < 30; n++) begin
      do_txn(1'($urandom), 12'($urandom), $urandom, 4'($urandom),
             int'($urandom_range(0, 6)), $urandom, 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
